// File: rtl/lzy_hc165_defs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lzy_hc165_defs : shared state encodings and defaults for the '165    |
// |                  scan controller, its bench and behavioural model    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lzy_hc165_defs;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int c_DEF_N_BITS  = 8;
    localparam int c_DEF_CLK_DIV = 1;

    function automatic logic is_busy(input state_t s);
        return (s == LOAD) || (s == SHIFT_LO) || (s == SHIFT_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lzy_hc165_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lzy_hc165_ctrl_if : pin bundle between the scan controller (master)  |
// |                     and the 74HC165 device (slave)                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface lzy_hc165_ctrl_if;
    logic hc_PL;
    logic hc_CE;
    logic hc_CP;
    logic hc_Ds;
    logic hc_Q7;

    modport master (output hc_PL, output hc_CE, output hc_CP, output hc_Ds, input  hc_Q7);
    modport slave  (input  hc_PL, input  hc_CE, input  hc_CP, input  hc_Ds, output hc_Q7);
endinterface
`default_nettype wire

// File: rtl/lzy_hc165_ctrl_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lzy_phase_timer : counts CLK_DIV cycles, tick on the last cycle of   |
// |                   each phase; clr restarts the phase                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lzy_phase_timer #(
    parameter int CLK_DIV = 1
) (
    input  wire logic Clk,
    input  wire logic Reset,
    input  wire logic clr,
    output logic      tick
);
    localparam int c_W = $clog2(CLK_DIV) + 1;

    logic [c_W-1:0] r_cnt;
    logic           w_last;

    assign w_last = (r_cnt == c_W'(CLK_DIV - 1));
    assign tick   = w_last;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt <= '0;
        end else if (clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/lzy_hc165.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lzy_hc165_ctrl : drives PL/CE/CP of a 74HC165, shifts Q7 in MSB      |
// |                  first and publishes the word with a done pulse      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lzy_hc165_ctrl
    import lzy_hc165_defs::*;
#(
    parameter int N_BITS  = c_DEF_N_BITS,
    parameter int CLK_DIV = c_DEF_CLK_DIV,
    parameter int AUTO    = 0
) (
    input  wire logic              Clk,
    input  wire logic              Reset,
    input  wire logic              start,
    input  wire logic              abort,
    lzy_hc165_ctrl_if.master       hc,
    output logic                   busy,
    output logic                   done,
    output logic [N_BITS-1:0]      data
);
    localparam int          c_BW   = $clog2(N_BITS) + 1;
    localparam logic [c_BW-1:0] c_LAST = c_BW'(N_BITS - 1);

    state_t            r_state, w_next;
    logic [N_BITS-1:0] r_sr, w_sr_next;
    logic [c_BW-1:0]   r_bit_cnt;
    logic              w_tick, w_sample, w_clr;
    logic              r_pl, r_ce, r_cp, r_busy, r_done;
    logic [N_BITS-1:0] r_data;

    lzy_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    assign w_sr_next = {r_sr[N_BITS-2:0], hc.hc_Q7};
    assign w_clr     = (w_next != r_state);

    always_comb begin
        w_next   = r_state;
        w_sample = 1'b0;
        case (r_state)
            IDLE:     if (start || (AUTO != 0)) w_next = LOAD;
            LOAD:     if (abort) w_next = IDLE;
                      else if (w_tick) w_next = SHIFT_LO;
            SHIFT_LO: if (abort) w_next = IDLE;
                      else if (w_tick) begin
                          w_sample = 1'b1;
                          w_next   = (r_bit_cnt == c_LAST) ? DONE : SHIFT_HI;
                      end
            SHIFT_HI: if (abort) w_next = IDLE;
                      else if (w_tick) w_next = SHIFT_LO;
            DONE:     w_next = (AUTO != 0) ? LOAD : IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Pin outputs are registered decodes of the next state, so they change
    // together with the state register and never glitch.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_data    <= '0;
            r_pl      <= 1'b1;
            r_ce      <= 1'b1;
            r_cp      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_sample) begin
                r_sr      <= w_sr_next;
                r_bit_cnt <= r_bit_cnt + c_BW'(1);
            end else if (w_next == IDLE || w_next == LOAD) begin
                r_bit_cnt <= '0;
            end
            if (w_sample && w_next == DONE) r_data <= w_sr_next;
            r_pl   <= (w_next != LOAD);
            r_ce   <= !(w_next == SHIFT_LO || w_next == SHIFT_HI);
            r_cp   <= (w_next == SHIFT_HI);
            r_busy <= is_busy(w_next);
            r_done <= (w_next == DONE);
        end
    end

    assign hc.hc_PL = r_pl;
    assign hc.hc_CE = r_ce;
    assign hc.hc_CP = r_cp;
    assign hc.hc_Ds = 1'b0;
    assign busy     = r_busy;
    assign done     = r_done;
    assign data     = r_data;
endmodule
`default_nettype wire

// File: tb/tb_lzy_hc165_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lzy_hc165_ctrl : directed bench, three controller configurations  |
// |                     each driving a behavioural 74HC165               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_lzy_hc165_ctrl;
    import lzy_hc165_defs::*;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic rst_n = 1'b0, rst_a = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0, abort0 = 1'b0;
    logic zero = 1'b0;
    logic busy0, busy1, busy2, done0, done1, done2;
    logic [7:0] data0, data1, data2;
    logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00;
    logic [7:0] m0 = 8'h00, m1 = 8'h00, m2 = 8'h00;
    int cp0 = 0, cp1 = 0, dcnt0 = 0;
    int n_assert = 0, n_fail = 0;

    lzy_hc165_ctrl_if bus0 ();
    lzy_hc165_ctrl_if bus1 ();
    lzy_hc165_ctrl_if bus2 ();

    lzy_hc165_ctrl #(.N_BITS(8), .CLK_DIV(1), .AUTO(0)) u_d1 (
        .Clk(Clk), .Reset(rst_n), .start(start0), .abort(abort0), .hc(bus0.master),
        .busy(busy0), .done(done0), .data(data0));
    lzy_hc165_ctrl #(.N_BITS(8), .CLK_DIV(2), .AUTO(0)) u_d2 (
        .Clk(Clk), .Reset(rst_n), .start(start1), .abort(zero), .hc(bus1.master),
        .busy(busy1), .done(done1), .data(data1));
    lzy_hc165_ctrl #(.N_BITS(8), .CLK_DIV(1), .AUTO(1)) u_auto (
        .Clk(Clk), .Reset(rst_a), .start(zero), .abort(zero), .hc(bus2.master),
        .busy(busy2), .done(done2), .data(data2));

    // '165 models: level load while PL low, shift on CP rise while CE low
    always @(negedge bus0.hc_PL or posedge bus0.hc_CP)
        if (!bus0.hc_PL) m0 = d0; else if (!bus0.hc_CE) m0 = {m0[6:0], bus0.hc_Ds};
    always @(negedge bus1.hc_PL or posedge bus1.hc_CP)
        if (!bus1.hc_PL) m1 = d1; else if (!bus1.hc_CE) m1 = {m1[6:0], bus1.hc_Ds};
    always @(negedge bus2.hc_PL or posedge bus2.hc_CP)
        if (!bus2.hc_PL) m2 = d2; else if (!bus2.hc_CE) m2 = {m2[6:0], bus2.hc_Ds};
    assign bus0.hc_Q7 = m0[7];
    assign bus1.hc_Q7 = m1[7];
    assign bus2.hc_Q7 = m2[7];

    always @(posedge bus0.hc_CP) cp0++;
    always @(posedge bus1.hc_CP) cp1++;
    always @(posedge Clk) if (done0 === 1'b1) dcnt0++;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_done(input int w);
        return (w == 0) ? done0 : (w == 1) ? done1 : done2;
    endfunction

    task automatic wait_done(input int w, output int lat);
        lat = 0;
        while (sel_done(w) !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
    endtask

    int lat, base, dbase;

    initial begin
        // reset state
        repeat (3) step();
        chk("rst_pl", bus0.hc_PL, 1);   chk("rst_ce", bus0.hc_CE, 1);
        chk("rst_cp", bus0.hc_CP, 0);   chk("rst_ds", bus0.hc_Ds, 0);
        chk("rst_busy", busy0, 0);      chk("rst_done", done0, 0);
        chk("rst_data", data0, 8'h00);
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_busy", busy0, 0);     chk("idle_pl", bus0.hc_PL, 1);

        // CLK_DIV=1 scan of A5
        d0 = 8'hA5; base = cp0; start0 = 1'b1;
        step(); start0 = 1'b0;
        chk("t2_pl_lo", bus0.hc_PL, 0); chk("t2_busy", busy0, 1);
        step();
        chk("t2_pl_hi", bus0.hc_PL, 1); chk("t2_ce", bus0.hc_CE, 0);
        wait_done(0, lat);
        chk("t2_lat", lat, 15);         chk("t2_data", data0, 8'hA5);
        chk("t2_cp_edges", cp0 - base, 7);
        step();
        chk("t2_done_1cyc", done0, 0);  chk("t2_idle", busy0, 0);

        // abort after the third sample
        d0 = 8'hFF; start0 = 1'b1;
        step(); start0 = 1'b0;
        repeat (6) step();
        chk("t5_in_hi", bus0.hc_CP, 1);
        abort0 = 1'b1;
        step(); abort0 = 1'b0;
        chk("t5_busy", busy0, 0);       chk("t5_ce", bus0.hc_CE, 1);
        chk("t5_pl", bus0.hc_PL, 1);    chk("t5_cp", bus0.hc_CP, 0);
        dbase = dcnt0;
        repeat (20) step();
        chk("t5_no_done", dcnt0 - dbase, 0);
        chk("t5_data_kept", data0, 8'hA5);
        start0 = 1'b1;
        step(); start0 = 1'b0;
        wait_done(0, lat);
        chk("t5_lat", lat, 16);         chk("t5_data_ff", data0, 8'hFF);

        // asynchronous reset mid-scan
        d0 = 8'hA5; start0 = 1'b1;
        step(); start0 = 1'b0;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        chk("t1_pl", bus0.hc_PL, 1);    chk("t1_ce", bus0.hc_CE, 1);
        chk("t1_cp", bus0.hc_CP, 0);    chk("t1_busy", busy0, 0);
        chk("t1_done", done0, 0);       chk("t1_data", data0, 8'h00);
        step(); rst_n = 1'b1;
        repeat (5) step();
        chk("t1_stay_idle", busy0, 0);  chk("t1_stay_pl", bus0.hc_PL, 1);

        // start held through two scans
        d0 = 8'hA5; start0 = 1'b1;
        step();
        chk("t4_busy", busy0, 1);
        wait_done(0, lat);
        chk("t4_lat1", lat, 16);        chk("t4_data1", data0, 8'hA5);
        d0 = 8'h5A;
        step();
        chk("t4_gap_busy", busy0, 0);   chk("t4_gap_pl", bus0.hc_PL, 1);
        step();
        chk("t4_reload", bus0.hc_PL, 0);
        wait_done(0, lat);
        chk("t4_lat2", lat, 16);        chk("t4_data2", data0, 8'h5A);
        start0 = 1'b0;
        repeat (2) step();
        chk("t4_end_idle", busy0, 0);

        // CLK_DIV=2 scan of 3C
        d1 = 8'h3C; base = cp1; start1 = 1'b1;
        step(); start1 = 1'b0;
        chk("t3_pl_c1", bus1.hc_PL, 0);
        step(); chk("t3_pl_c2", bus1.hc_PL, 0);
        step(); chk("t3_pl_c3", bus1.hc_PL, 1); chk("t3_ce", bus1.hc_CE, 0);
        chk("t3_cp_c3", bus1.hc_CP, 0);
        step(); chk("t3_cp_c4", bus1.hc_CP, 0);
        step(); chk("t3_cp_c5", bus1.hc_CP, 1);
        step(); chk("t3_cp_c6", bus1.hc_CP, 1);
        step(); chk("t3_cp_c7", bus1.hc_CP, 0);
        wait_done(1, lat);
        chk("t3_lat", lat, 26);         chk("t3_data", data1, 8'h3C);
        chk("t3_cp_edges", cp1 - base, 7);
        step(); chk("t3_done_1cyc", done1, 0);

        // AUTO=1 back-to-back scans
        d2 = 8'h01; rst_a = 1'b1;
        wait_done(2, lat);
        chk("t6_first", lat, 17);       chk("t6_data1", data2, 8'h01);
        d2 = 8'h80;
        step();
        chk("t6_no_gap", busy2, 1);     chk("t6_pl", bus2.hc_PL, 0);
        wait_done(2, lat);
        chk("t6_period", lat, 16);      chk("t6_data2", data2, 8'h80);
        lat = 0;
        while (bus2.hc_CP !== 1'b1 && lat < 50) begin step(); lat++; end
        chk("t6_in_hi", bus2.hc_CP, 1);
        #2 rst_a = 1'b0;
        #1;
        chk("t6_rst_cp", bus2.hc_CP, 0); chk("t6_rst_pl", bus2.hc_PL, 1);
        chk("t6_rst_ce", bus2.hc_CE, 1); chk("t6_rst_busy", busy2, 0);
        chk("t6_rst_data", data2, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
